// File: rtl/audio_mix_sequencer_pkg.sv
// audio_pkg: shared definitions for the audio mix sequencer.
//   - config address constants for the byte-wide volume port
//   - unity volume and the gain shift (gain = vol / 2**VOL_SHIFT)
//   - mix FSM state enum (also exported on the debug port)
//   - sat16(): clamp a signed 32-bit value to the signed 16-bit range
package audio_pkg;

    localparam logic [3:0] CFG_VOL_L_BASE = 4'd0;
    localparam logic [3:0] CFG_VOL_R_BASE = 4'd8;
    localparam logic [3:0] CFG_OVR_CLR    = 4'hF;

    localparam logic [7:0] UNITY_VOL = 8'd128;
    localparam int         VOL_SHIFT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DRAIN,
        ST_SAT
    } mix_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/audio_mix_sequencer_mac_pipe.sv
// audio_mac_pipe: 3-stage shared multiply-accumulate for the mix sequencer.
//   Stage 1 registers the operand pair (source sample, volume) and its L/R tag.
//   Stage 2 registers (src * vol) >>> VOL_SHIFT, sign-extended to ACC_W.
//   Stage 3 adds the product into acc_l (tag=0) or acc_r (tag=1).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           zero both accumulators (asserted while loading a frame)
//   in_valid        an operand pair is presented this cycle
//   in_tag          0 = left accumulator, 1 = right accumulator
//   in_src, in_vol  signed 16-bit sample, unsigned 8-bit volume
//   acc_l, acc_r    signed accumulators
module audio_mac_pipe
    import audio_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic                    in_tag,
    input  logic signed [15:0]      in_src,
    input  logic        [7:0]       in_vol,
    output logic signed [ACC_W-1:0] acc_l,
    output logic signed [ACC_W-1:0] acc_r
);

    // Bits of the 25-bit product that survive the gain shift.
    localparam int SH_W = 25 - VOL_SHIFT;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_tag_q, s1_tag_d;
    logic signed [15:0]      s1_src_q, s1_src_d;
    logic        [7:0]       s1_vol_q, s1_vol_d;
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_tag_q, s2_tag_d;
    logic signed [ACC_W-1:0] s2_prod_q, s2_prod_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
    logic signed [24:0]      prod_full;
    logic                    unused_lsbs;

    always_comb begin
        s1_valid_d = in_valid;
        s1_tag_d   = in_tag;
        s1_src_d   = in_src;
        s1_vol_d   = in_vol;

        // Volume is unsigned; the zero MSB keeps 255 from reading as -1.
        prod_full  = s1_src_q * $signed({1'b0, s1_vol_q});
        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        s2_prod_d  = {{(ACC_W-SH_W){prod_full[24]}}, prod_full[24:VOL_SHIFT]};

        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (clear) begin
            acc_l_d = '0;
            acc_r_d = '0;
        end else if (s2_valid_q) begin
            if (s2_tag_q) begin
                acc_r_d = acc_r_q + s2_prod_q;
            end else begin
                acc_l_d = acc_l_q + s2_prod_q;
            end
        end
    end

    // Fractional bits are discarded by the arithmetic shift.
    assign unused_lsbs = ^prod_full[VOL_SHIFT-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_src_q   <= '0;
            s1_vol_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
            s2_prod_q  <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_src_q   <= s1_src_d;
            s1_vol_q   <= s1_vol_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_prod_q  <= s2_prod_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
        end
    end

    assign acc_l = acc_l_q;
    assign acc_r = acc_r_q;

endmodule

// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: per-sample stereo mixer sharing one multiplier across
// NUM_SRC sources, with per-source per-side volume (gain = vol/128) and
// saturation to signed 16 bits. One output sample per sample_strobe.
// Optional build macro AUDIO_MIX_VOL_RAMP_EN: active volumes step by at most
// 1 per frame toward the written (shadow) value instead of jumping.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sample_strobe         one-cycle pulse starting a mix frame
//   src_l, src_r          packed signed 16-bit sources, source i at [16*i +: 16]
//   mute                  zero the sample produced while it is high in SAT
//   cfg_we/addr/data      volume writes (0..N-1 left, 8..8+N-1 right), F clears overrun
//   audio_l, audio_r      saturated output sample, held between frames
//   sample_valid          one-cycle pulse when audio_l/audio_r update
//   busy, overrun         frame in progress / sticky strobe-while-busy flag
//   dbg_state             current FSM state
// Handshake: sample_strobe has no back-pressure; a strobe while busy is dropped
// and recorded in overrun. sample_valid is a pure pulse with no ready.
module audio_mix_sequencer
    import audio_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int ACC_W   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_strobe,
    input  logic [NUM_SRC*16-1:0]  src_l,
    input  logic [NUM_SRC*16-1:0]  src_r,
    input  logic                   mute,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [7:0]             cfg_data,
    output logic [15:0]            audio_l,
    output logic [15:0]            audio_r,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun,
    output mix_state_e             dbg_state
);

    localparam int               IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [3:0]       NUM_SRC4 = 4'(NUM_SRC);
    localparam logic [4:0]       N_CNT    = 5'(NUM_SRC);
    localparam logic [4:0]       MAC_LAST = 5'(2*NUM_SRC - 1);

    mix_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        sample_valid_q, sample_valid_d;
    logic [15:0] audio_l_q, audio_l_d;
    logic [15:0] audio_r_q, audio_r_d;
    logic [7:0]  shadow_l_q [NUM_SRC];
    logic [7:0]  shadow_l_d [NUM_SRC];
    logic [7:0]  shadow_r_q [NUM_SRC];
    logic [7:0]  shadow_r_d [NUM_SRC];
    logic [7:0]  active_l_q [NUM_SRC];
    logic [7:0]  active_l_d [NUM_SRC];
    logic [7:0]  active_r_q [NUM_SRC];
    logic [7:0]  active_r_d [NUM_SRC];
    logic [15:0] frame_l_q  [NUM_SRC];
    logic [15:0] frame_l_d  [NUM_SRC];
    logic [15:0] frame_r_q  [NUM_SRC];
    logic [15:0] frame_r_d  [NUM_SRC];

    logic [IDX_W-1:0]        cfg_idx;
    logic [IDX_W-1:0]        mac_idx;
    logic [4:0]              cnt_off;
    logic                    mac_valid;
    logic                    mac_tag;
    logic [15:0]             mac_src;
    logic [7:0]              mac_vol;
    logic                    pipe_clear;
    logic signed [ACC_W-1:0] acc_l, acc_r;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        sample_valid_d = 1'b0;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        shadow_l_d     = shadow_l_q;
        shadow_r_d     = shadow_r_q;
        active_l_d     = active_l_q;
        active_r_d     = active_r_q;
        frame_l_d      = frame_l_q;
        frame_r_d      = frame_r_q;
        pipe_clear     = 1'b0;
        mac_valid      = 1'b0;

        // Config decode. Address F is reserved for the overrun clear even
        // when NUM_SRC=8 would otherwise map it to right volume 7.
        cfg_idx = IDX_W'(cfg_addr);
        if (cfg_we && !cfg_addr[3] && ({1'b0, cfg_addr[2:0]} < NUM_SRC4)) begin
            shadow_l_d[cfg_idx] = cfg_data;
        end
        if (cfg_we && cfg_addr[3] && (cfg_addr != CFG_OVR_CLR) &&
            ({1'b0, cfg_addr[2:0]} < NUM_SRC4)) begin
            shadow_r_d[cfg_idx] = cfg_data;
        end

        // Clear first so a same-cycle set takes priority.
        if (cfg_we && (cfg_addr == CFG_OVR_CLR)) begin
            overrun_d = 1'b0;
        end
        if (sample_strobe && busy_q) begin
            overrun_d = 1'b1;
        end

        // Operand mux: first N MAC cycles walk the left sources, then the right.
        mac_tag = (cnt_q >= N_CNT);
        cnt_off = mac_tag ? (cnt_q - N_CNT) : cnt_q;
        mac_idx = IDX_W'(cnt_off);
        mac_src = mac_tag ? frame_r_q[mac_idx]  : frame_l_q[mac_idx];
        mac_vol = mac_tag ? active_r_q[mac_idx] : active_l_q[mac_idx];

        case (state_q)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    frame_l_d[i] = src_l[16*i +: 16];
                    frame_r_d[i] = src_r[16*i +: 16];
`ifdef AUDIO_MIX_VOL_RAMP_EN
                    if (shadow_l_q[i] > active_l_q[i]) begin
                        active_l_d[i] = active_l_q[i] + 8'd1;
                    end else if (shadow_l_q[i] < active_l_q[i]) begin
                        active_l_d[i] = active_l_q[i] - 8'd1;
                    end
                    if (shadow_r_q[i] > active_r_q[i]) begin
                        active_r_d[i] = active_r_q[i] + 8'd1;
                    end else if (shadow_r_q[i] < active_r_q[i]) begin
                        active_r_d[i] = active_r_q[i] - 8'd1;
                    end
`else
                    active_l_d[i] = shadow_l_q[i];
                    active_r_d[i] = shadow_r_q[i];
`endif
                end
                pipe_clear = 1'b1;
                cnt_d      = '0;
                state_d    = ST_MAC;
            end
            ST_MAC: begin
                mac_valid = 1'b1;
                if (cnt_q == MAC_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last operand pass stages 2 and 3.
                if (cnt_q == 5'd1) begin
                    cnt_d   = '0;
                    state_d = ST_SAT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_SAT: begin
                audio_l_d      = mute ? 16'd0 : sat16(32'(acc_l));
                audio_r_d      = mute ? 16'd0 : sat16(32'(acc_r));
                sample_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                shadow_l_q[i] <= UNITY_VOL;
                shadow_r_q[i] <= UNITY_VOL;
                active_l_q[i] <= UNITY_VOL;
                active_r_q[i] <= UNITY_VOL;
                frame_l_q[i]  <= '0;
                frame_r_q[i]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            sample_valid_q <= sample_valid_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            shadow_l_q     <= shadow_l_d;
            shadow_r_q     <= shadow_r_d;
            active_l_q     <= active_l_d;
            active_r_q     <= active_r_d;
            frame_l_q      <= frame_l_d;
            frame_r_q      <= frame_r_d;
        end
    end

    audio_mac_pipe #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (pipe_clear),
        .in_valid (mac_valid),
        .in_tag   (mac_tag),
        .in_src   (mac_src),
        .in_vol   (mac_vol),
        .acc_l    (acc_l),
        .acc_r    (acc_r)
    );

    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Directed bench for audio_mix_sequencer (NUM_SRC=6, ACC_W=24).
// Expected samples are hand-computed and queued in exp_q; each sample_valid
// pops one entry. Build with AUDIO_MIX_VOL_RAMP_EN to exercise the ramp path.
`timescale 1ns/1ps
module tb_audio_mix_sequencer;
    import audio_pkg::*;

    localparam int NUM_SRC = 6;
    localparam int ACC_W   = 24;
    localparam int LAT     = 2*NUM_SRC + 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sample_strobe;
    logic [NUM_SRC*16-1:0] src_l;
    logic [NUM_SRC*16-1:0] src_r;
    logic                  mute;
    logic                  cfg_we;
    logic [3:0]            cfg_addr;
    logic [7:0]            cfg_data;
    logic [15:0]           audio_l;
    logic [15:0]           audio_r;
    logic                  sample_valid;
    logic                  busy;
    logic                  overrun;
    mix_state_e            dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1);
    end

    audio_mix_sequencer #(
        .NUM_SRC (NUM_SRC),
        .ACC_W   (ACC_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .src_l         (src_l),
        .src_r         (src_r),
        .mute          (mute),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .audio_l       (audio_l),
        .audio_r       (audio_r),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back({l, r});
    endtask

    // ---------------- drivers ----------------
    task automatic set_all(input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < NUM_SRC; i++) begin
            src_l[16*i +: 16] = l;
            src_r[16*i +: 16] = r;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Issues one strobe, then watches 40 cycles. Optional extras at cycle k
    // (relative to the strobe): a second strobe, an overrun-clear write, or a
    // one-cycle reset. -1 disables an extra.
    task automatic frame(input int extra_at, input int cfg_at, input int rst_at,
                         input int exp_pulses, input string tag);
        int lat    = 0;
        int pulses = 0;
        sample_strobe = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            sample_strobe = (k == extra_at);
            cfg_we        = (k == cfg_at);
            cfg_addr      = CFG_OVR_CLR;
            cfg_data      = 8'h00;
            reset         = (k == rst_at);
            if (k == 1) check({tag, "_busy_start"}, 32'(busy), 32'd1);
            if (sample_valid) begin
                pulses++;
                if (lat == 0) lat = k;
                check({tag, "_exp_avail"}, 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check({tag, "_sample"}, {audio_l, audio_r}, exp_q.pop_front());
            end
        end
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        sample_strobe = 1'b0;
        mute          = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        src_l         = '0;
        src_r         = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        check("rst_audio_l", 32'(audio_l), 32'd0);
        check("rst_audio_r", 32'(audio_r), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Unity volumes: 6 x 1000.
        set_all(16'sd1000, 16'sd1000);
        push_exp(16'sd6000, 16'sd6000);
        frame(-1, -1, -1, 1, "unity");

        // Output holds between frames.
        set_all(16'sd0, 16'sd0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_l", 32'(audio_l), 32'(16'sd6000));
        check("hold_r", 32'(audio_r), 32'(16'sd6000));
        check("hold_valid", 32'(sample_valid), 32'd0);

`ifdef AUDIO_MIX_VOL_RAMP_EN
        // L0 128 -> 132 ramps one step per frame: 1000*g>>7.
        cfg_write(4'd0, 8'd132);
        src_l[15:0] = 16'sd1000;
        src_r[15:0] = 16'sd1000;
        push_exp(16'sd1007, 16'sd1000);
        push_exp(16'sd1015, 16'sd1000);
        push_exp(16'sd1023, 16'sd1000);
        push_exp(16'sd1031, 16'sd1000);
        push_exp(16'sd1031, 16'sd1000);
        for (int f = 0; f < 5; f++) frame(-1, -1, -1, 1, "ramp_up");
        cfg_write(4'd0, 8'd128);
        push_exp(16'sd1023, 16'sd1000);
        push_exp(16'sd1015, 16'sd1000);
        push_exp(16'sd1007, 16'sd1000);
        push_exp(16'sd1000, 16'sd1000);
        for (int f = 0; f < 4; f++) frame(-1, -1, -1, 1, "ramp_down");
`else
        // L0 silent, R0 at 255: 1000*255>>7 = 1992.
        cfg_write(CFG_VOL_L_BASE, 8'd0);
        cfg_write(CFG_VOL_R_BASE, 8'd255);
        src_l[15:0] = 16'sd1000;
        src_r[15:0] = 16'sd1000;
        push_exp(16'sd0, 16'sd1992);
        frame(-1, -1, -1, 1, "vol");

        // All volumes 255; unused addresses must have no effect.
        for (int i = 0; i < NUM_SRC; i++) begin
            cfg_write(4'(i), 8'd255);
            cfg_write(4'(8 + i), 8'd255);
        end
        cfg_write(4'd7, 8'd0);
        cfg_write(4'd14, 8'd0);
        set_all(16'sh7FFF, 16'sh7FFF);
        push_exp(16'sh7FFF, 16'sh7FFF);
        frame(-1, -1, -1, 1, "sat_pos");
        set_all(16'sh8000, 16'sh8000);
        push_exp(16'sh8000, 16'sh8000);
        frame(-1, -1, -1, 1, "sat_neg");

        for (int i = 0; i < NUM_SRC; i++) begin
            cfg_write(4'(i), UNITY_VOL);
            cfg_write(4'(8 + i), UNITY_VOL);
        end
`endif

        // Overrun: strobe mid-frame, strobe in SAT, and set-vs-clear collision.
        set_all(16'sd1000, 16'sd1000);
        push_exp(16'sd6000, 16'sd6000);
        frame(5, -1, -1, 1, "ovr_mid");
        check("ovr_mid_flag", 32'(overrun), 32'd1);
        cfg_write(CFG_OVR_CLR, 8'h5A);
        check("ovr_clear", 32'(overrun), 32'd0);

        push_exp(16'sd6000, 16'sd6000);
        frame(LAT - 1, -1, -1, 1, "ovr_sat");
        check("ovr_sat_flag", 32'(overrun), 32'd1);
        cfg_write(CFG_OVR_CLR, 8'h00);
        check("ovr_clear2", 32'(overrun), 32'd0);

        push_exp(16'sd6000, 16'sd6000);
        frame(8, 8, -1, 1, "ovr_setwins");
        check("ovr_setwins_flag", 32'(overrun), 32'd1);
        cfg_write(CFG_OVR_CLR, 8'h00);
        check("ovr_clear3", 32'(overrun), 32'd0);

        // Mute zeroes the sample but still pulses.
        set_all(16'sd500, 16'sd500);
        mute = 1'b1;
        push_exp(16'd0, 16'd0);
        frame(-1, -1, -1, 1, "mute");
        mute = 1'b0;
        push_exp(16'sd3000, 16'sd3000);
        frame(-1, -1, -1, 1, "unmute");

        // Reset mid-frame: no pulse, everything back to reset values,
        // including the halved L0 volume and the overrun raised at cycle 3.
        cfg_write(CFG_VOL_L_BASE, 8'd64);
        set_all(16'sd1000, 16'sd1000);
        frame(3, -1, 8, 0, "rst_mid");
        check("rst_mid_audio_l", 32'(audio_l), 32'd0);
        check("rst_mid_audio_r", 32'(audio_r), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        push_exp(16'sd6000, 16'sd6000);
        frame(-1, -1, -1, 1, "post_rst");

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_mix_sequencer.md
Name: audio_mix_sequencer

Overview:
- Per-sample mix scheduler that shares one signed 16x9 multiplier and one accumulator pair across NUM_SRC stereo sources, applying a per-source, per-side volume to each.
- Placed after the per-chip sound generators (PSG, FM, covox, SAA, GS), which already deliver 16-bit signed L/R.
- Produces one saturated signed 16-bit stereo sample per sample_strobe for the DAC/I2S serializer.
- Volumes are set through a byte-wide config port from the ZX port decoder.

Parameters:
- NUM_SRC, 6, number of stereo sources; legal range 1..8.
- ACC_W, 24, accumulator width in bits; must be at least 19 + clog2(NUM_SRC).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active high
- sample_strobe  in  1  one-cycle pulse at the output sample rate (48 kHz)
- src_l  in  NUM_SRC*16  packed signed left inputs; source i at [16*i+15:16*i]
- src_r  in  NUM_SRC*16  packed signed right inputs, same packing
- mute  in  1  forces output samples to 0
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  config address
- cfg_data  in  8  config write data
- audio_l  out  16  signed left sample
- audio_r  out  16  signed right sample
- sample_valid  out  1  one-cycle pulse when audio_l/audio_r update
- busy  out  1  frame in progress
- overrun  out  1  sticky: a strobe arrived while busy

Behaviour:
- Reset values:
  - audio_l, audio_r, sample_valid, busy, overrun all 0.
  - All shadow and active volumes = 8'd128 (unity).
  - FSM in IDLE; accumulators 0.
- Config map:
  - addr 0..NUM_SRC-1: left volume of source addr.
  - addr 8..8+NUM_SRC-1: right volume of source addr-8.
  - addr 4'hF: any write clears overrun.
  - All other addresses are ignored.
  - Writes update shadow registers on the same cycle and are legal at any time.
- Gain: vol/128. 0 = silent, 128 = unity, 255 ≈ 1.99x.
- FSM states: IDLE, LOAD, MAC, DRAIN, SAT.
  - IDLE: on sample_strobe go to LOAD and set busy=1.
  - LOAD, one cycle:
    - Snapshot src_l/src_r into frame registers.
    - Copy shadow volumes to active volumes.
    - Clear acc_l and acc_r.
  - MAC, 2*NUM_SRC cycles, one operand pair issued per cycle, order L0..L(N-1) then R0..R(N-1).
    - Stage 1: operand mux register.
    - Stage 2: product = src * $signed({1'b0,vol}), 25 bits, arithmetically shifted right by 7, sign-extended to ACC_W.
    - Stage 3: product is added into acc_l or acc_r according to a tag carried with it.
  - DRAIN, 2 cycles: flush the pipeline.
  - SAT, one cycle:
    - Clamp each accumulator to [-32768, 32767].
    - Register audio_l/audio_r, or 0 if mute=1 in this cycle.
    - Pulse sample_valid; busy=0; return to IDLE.
- Latency: sample_valid rises exactly 2*NUM_SRC+5 cycles after the strobe cycle (17 cycles for NUM_SRC=6).
- audio_l/audio_r hold their value between frames.
- A sample_strobe while busy=1, including in the SAT cycle, is ignored and sets overrun.
- Same-cycle overrun set and 4'hF clear: set wins.
- A cfg write in the LOAD cycle reaches the shadow only; it is applied at the next frame.
- Reset asserted mid-frame: abort immediately, with no sample_valid pulse; all reset values apply.

Optional Feature:
- Macro: AUDIO_MIX_VOL_RAMP_EN.
- Defined:
  - In LOAD, each active volume steps by at most 1 toward its shadow value instead of copying it.
  - Example: a 0→128 change takes 128 frames, avoiding zipper clicks.
  - Behaviour at reset is unchanged: shadow and active volumes are both 128.
- Undefined: active volume = shadow volume, copied at LOAD.

Decomposition:
- Shared package audio_pkg holds:
  - Config address constants: CFG_VOL_L_BASE=0, CFG_VOL_R_BASE=8, CFG_OVR_CLR=4'hF.
  - UNITY_VOL=8'd128 and VOL_SHIFT=7.
  - The FSM state enum.
  - A saturate-to-16 function.
- One sub-module, audio_mac_pipe, holds the 3-stage multiply-accumulate with the L/R tag.
- The top level keeps the FSM, volume registers and config decode.

Test Plan:
- Reset, then strobe with all sources = 16'sd1000 and default volumes, NUM_SRC=6 → after 17 cycles audio_l = audio_r = 6000, single sample_valid pulse.
- Write vol L0=0 and vol R0=255; src0 = 16'sd1000, others 0; strobe → audio_l=0, audio_r=1992.
- All sources = 16'sh7FFF, all volumes 255 → audio_l=32767; all sources = 16'sh8000 → audio_l=-32768.
- Strobe again 5 cycles after the first → overrun=1 and only one sample_valid; write addr 4'hF → overrun=0.
- mute=1 during a frame with sources = 16'sd500 → audio_l = audio_r = 0 and sample_valid still pulses.
- Reset 8 cycles into a frame → no sample_valid, outputs 0, and the next strobe yields a correct sample; with AUDIO_MIX_VOL_RAMP_EN, vol L0 write 128→132 gives gains 129, 130, 131, 132 over 4 frames.
